// File: rtl/banco_registros_param.sv
// Parameterised two-read/one-write register file with a bulk-clear sweep FSM.
// Define BANCO_REGISTROS_BYPASS_EN to forward same-cycle write data onto the read ports.
module banco_registros_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    Read_Reg1,
    input  logic [AW-1:0]    Read_Reg2,
    input  logic [AW-1:0]    Write_Reg,
    input  logic [WIDTH-1:0] Write_Data,
    input  logic             RegWrite,
    input  logic             Clear,
    output logic             Busy,
    output logic [WIDTH-1:0] Read_data1,
    output logic [WIDTH-1:0] Read_data2
);

    localparam logic [0:0]    S_IDLE   = 1'b0;
    localparam logic [0:0]    S_CLEAR  = 1'b1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    w_ptr_nxt;
    logic             w_wr_en;

    // An address is backed by storage unless it is out of range or the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign Busy    = (r_state == S_CLEAR);
    assign w_wr_en = RegWrite && (r_state == S_IDLE) && addr_ok(Write_Reg);

    // Sweep controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Sweep controller next state: Clear is only honoured from IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (Clear) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_ptr_nxt = r_ptr + AW'(1);
                if (r_ptr == LAST_PTR) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Storage: sweep zeroing has priority; user writes are only taken in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '{default: '0};
        end else if (r_state == S_CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_en) begin
            r_mem[Write_Reg] <= Write_Data;
        end
    end

    // Combinational read ports
    always_comb begin
        Read_data1 = '0;
        Read_data2 = '0;
        if (addr_ok(Read_Reg1)) Read_data1 = r_mem[Read_Reg1];
        if (addr_ok(Read_Reg2)) Read_data2 = r_mem[Read_Reg2];
`ifdef BANCO_REGISTROS_BYPASS_EN
        if (w_wr_en && (Read_Reg1 == Write_Reg)) Read_data1 = Write_Data;
        if (w_wr_en && (Read_Reg2 == Write_Reg)) Read_data2 = Write_Data;
`endif
    end

endmodule

// File: tb/tb_banco_registros_param.sv
// Self-checking bench for banco_registros_param: random traffic against an array model,
// clear-sweep timing, mid-sweep reset and the write/clear collision.
module tb_banco_registros_param;

    localparam int unsigned W = 32;
    localparam int unsigned D = 32;
    localparam int unsigned A = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [A-1:0] rr1, rr2, wr;
    logic [W-1:0] wd;
    logic         we, clr;
    logic         busy;
    logic [W-1:0] rd1, rd2;

    logic [W-1:0] m   [D];
    logic [W-1:0] old [D];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    banco_registros_param #(.WIDTH(W), .DEPTH(D), .AW(A), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .Read_Reg1(rr1), .Read_Reg2(rr2), .Write_Reg(wr), .Write_Data(wd),
        .RegWrite(we), .Clear(clr), .Busy(busy),
        .Read_data1(rd1), .Read_data2(rd2)
    );

    // Stored value as seen after all committed edges (r0 is always zero)
    function automatic logic [W-1:0] exp_rd(input logic [A-1:0] a);
        if (a == '0) return '0;
        return m[a];
    endfunction

    // Value seen before the edge, accounting for an in-flight write when bypass is built in
    function automatic logic [W-1:0] exp_pre(input logic [A-1:0] a);
`ifdef BANCO_REGISTROS_BYPASS_EN
        if (we && (a == wr) && (a != '0)) return wd;
`endif
        return exp_rd(a);
    endfunction

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d);
        we = 1'b1; wr = a; wd = d;
        edge1();
        we = 1'b0;
        if (a != '0) m[a] = d;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < int'(D); i++) begin
            rr1 = A'(i); rr2 = A'(D - 1 - i);
            #1;
            n_tests++;
            if (rd1 !== '0 || rd2 !== '0) begin
                n_fail++;
                $display("FAIL %s addr=%0d rd1=%h rd2=%h expected 0", tag, i, rd1, rd2);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; we = 1'b0; clr = 1'b0; rr1 = '0; rr2 = '0; wr = '0; wd = '0;
        for (int i = 0; i < int'(D); i++) m[i] = '0;
        #3;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy busy=%b expected 0", busy);
        end
        edge1();
        rst_n = 1'b1;
        edge1();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_after busy=%b expected 0", busy);
        end
        check_all_zero("reset_read");
    endtask

    task automatic test_basic();
        do_write(A'(5), 32'hDEADBEEF);
        rr1 = A'(5); rr2 = A'(5);
        #1;
        n_tests++;
        if (rd1 !== 32'hDEADBEEF || rd2 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_r5 rd1=%h rd2=%h expected deadbeef", rd1, rd2);
        end
        do_write(A'(0), 32'h1);
        rr1 = A'(0);
        #1;
        n_tests++;
        if (rd1 !== '0) begin
            n_fail++;
            $display("FAIL zero_reg rd1=%h expected 0", rd1);
        end
    endtask

    task automatic test_bypass();
        do_write(A'(7), 32'h11112222);
        rr1 = A'(7); we = 1'b1; wr = A'(7); wd = 32'h12345678;
        #1;
        n_tests++;
`ifdef BANCO_REGISTROS_BYPASS_EN
        if (rd1 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_pre rd1=%h expected 12345678", rd1);
        end
`else
        if (rd1 !== 32'h11112222) begin
            n_fail++;
            $display("FAIL bypass_pre rd1=%h expected 11112222", rd1);
        end
`endif
        edge1();
        we = 1'b0;
        m[7] = 32'h12345678;
        n_tests++;
        if (rd1 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_post rd1=%h expected 12345678", rd1);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            rr1 = A'($urandom_range(D - 1));
            rr2 = (it % 4 == 0) ? rr1 : A'($urandom_range(D - 1));
            wr  = (it % 5 == 0) ? rr1 : A'($urandom_range(D - 1));
            wd  = $urandom;
            we  = ($urandom_range(1) == 1);
            #1;
            n_tests++;
            if (rd1 !== exp_pre(rr1) || rd2 !== exp_pre(rr2)) begin
                n_fail++;
                $display("FAIL random it=%0d a1=%0d rd1=%h exp1=%h a2=%0d rd2=%h exp2=%h",
                         it, rr1, rd1, exp_pre(rr1), rr2, rd2, exp_pre(rr2));
            end
            edge1();
            if (we && wr != '0) m[wr] = wd;
            we = 1'b0;
        end
    endtask

    task automatic fill_nonzero();
        for (int i = 1; i < int'(D); i++) do_write(A'(i), $urandom | 32'h1);
    endtask

    task automatic test_clear();
        int k;
        fill_nonzero();
        for (int i = 0; i < int'(D); i++) old[i] = exp_rd(A'(i));
        clr = 1'b1;
        edge1();
        clr = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 100) begin
            rr1 = A'(k);
            rr2 = (k == 0) ? A'(0) : A'(k - 1);
            if (k == 3) clr = 1'b1;
            if (k == 5) begin we = 1'b1; wr = A'(3); wd = 32'hFFFF0003; end
            #1;
            n_tests++;
            if (rd1 !== old[k % D] || rd2 !== '0) begin
                n_fail++;
                $display("FAIL sweep_read k=%0d rd1=%h exp1=%h rd2=%h exp2=0", k, rd1, old[k % D], rd2);
            end
            edge1();
            we = 1'b0; clr = 1'b0;
            m[k % D] = '0;
            k++;
        end
        n_tests++;
        if (k != int'(D)) begin
            n_fail++;
            $display("FAIL busy_len cycles=%0d expected %0d", k, D);
        end
        check_all_zero("after_clear");
    endtask

    task automatic test_reset_mid();
        fill_nonzero();
        clr = 1'b1;
        edge1();
        clr = 1'b0;
        for (int k = 0; k < 10; k++) edge1();
        rr1 = A'(20); rr2 = A'(31);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || rd1 !== '0 || rd2 !== '0) begin
            n_fail++;
            $display("FAIL reset_mid busy=%b rd1=%h rd2=%h expected 0 0 0", busy, rd1, rd2);
        end
        for (int i = 0; i < int'(D); i++) m[i] = '0;
        edge1();
        rst_n = 1'b1;
        edge1();
        edge1();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle busy=%b expected 0", busy);
        end
        check_all_zero("reset_mid_read");
        do_write(A'(4), 32'hCAFEF00D);
        rr1 = A'(4);
        #1;
        n_tests++;
        if (rd1 !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL reset_mid_write rd1=%h expected cafef00d", rd1);
        end
    endtask

    task automatic test_clear_write();
        int k;
        clr = 1'b1; we = 1'b1; wr = A'(9); wd = 32'hA5A5A5A5;
        edge1();
        clr = 1'b0; we = 1'b0;
        m[9] = 32'hA5A5A5A5;
        k = 0;
        while (busy === 1'b1 && k < 100) begin
            rr1 = A'(9);
            #1;
            n_tests++;
            if (rd1 !== m[9]) begin
                n_fail++;
                $display("FAIL clear_write k=%0d rd1=%h expected %h", k, rd1, m[9]);
            end
            edge1();
            m[k % D] = '0;
            k++;
        end
        n_tests++;
        if (k != int'(D) || rd1 !== '0) begin
            n_fail++;
            $display("FAIL clear_write_end cycles=%0d rd1=%h expected %0d and 0", k, rd1, D);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_random();
        test_clear();
        test_reset_mid();
        test_clear_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/banco_registros_param.md
BANCO_REGISTROS_PARAM -- requirements
Module: banco_registros_param

Interface
REQ-001 Parameter WIDTH, default 32: data width of each register in bits.
REQ-002 Parameter DEPTH, default 32: number of registers, range 2..256.
REQ-003 Parameter AW, default 5: address width, which SHALL satisfy 2**AW >= DEPTH.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-005 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 Read_Reg1  input  AW  read address, port 1.
REQ-008 Read_Reg2  input  AW  read address, port 2.
REQ-009 Write_Reg  input  AW  write address.
REQ-010 Write_Data  input  WIDTH  write data.
REQ-011 RegWrite  input  1  write enable, sampled on the clk rising edge.
REQ-012 Clear  input  1  single-cycle request to start the bulk-clear sweep.
REQ-013 Busy  output  1  high while the clear sweep is running.
REQ-014 Read_data1  output  WIDTH  read data, port 1 (combinational).
REQ-015 Read_data2  output  WIDTH  read data, port 2 (combinational).

Function
REQ-016 Reads SHALL be combinational from the register array with zero-cycle latency; both ports are independent and may address the same register.
REQ-017 Writes SHALL be synchronous: on a rising edge with RegWrite=1 and Busy=0, register[Write_Reg] <= Write_Data, visible on reads after that edge.
REQ-018 With ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0.
REQ-019 For addresses >= DEPTH, reads SHALL return 0 and writes SHALL be discarded.
REQ-020 The FSM SHALL have two states, IDLE and CLEAR; reset state is IDLE.
REQ-021 IDLE -> CLEAR SHALL occur on the edge where Clear=1; the sweep pointer loads 0 and Busy rises after that edge.
REQ-022 In CLEAR, each edge SHALL zero register[ptr] and increment ptr; after zeroing DEPTH-1 the FSM SHALL return to IDLE, so Busy is high for exactly DEPTH cycles.
REQ-023 Clear asserted while in CLEAR SHALL be ignored; the sweep does not restart.
REQ-024 RegWrite while Busy=1 SHALL be discarded, with no queuing.
REQ-025 If Clear=1 and RegWrite=1 on the same IDLE edge, the write SHALL commit on that edge and the subsequent sweep SHALL later zero it.
REQ-026 During CLEAR, reads SHALL return current array contents: 0 for swept entries, old values for entries not yet swept.

Reset
REQ-027 rst_n=0 SHALL immediately, independent of clk, zero all DEPTH registers, force the FSM to IDLE, zero ptr, and drive Busy=0.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep; after release the block is IDLE with all registers at 0.
REQ-029 Out of reset, Read_data1 and Read_data2 SHALL be 0 for every address.

Configuration
REQ-030 Macro BANCO_REGISTROS_BYPASS_EN enables write-through bypass.
REQ-031 With the macro defined: while RegWrite=1, Busy=0, Read_RegN==Write_Reg, and the address is writable, Read_dataN SHALL equal Write_Data combinationally in the same cycle.
REQ-032 Without the macro defined: Read_dataN SHALL show the pre-write value until the write edge; there is no bypass logic.

Verification
REQ-033 Reset, then read every address on both ports -> all reads return 0x00000000 and Busy=0.
REQ-034 Write 0xDEADBEEF to r5, then read r5 on both ports -> 0xDEADBEEF on the cycle after the edge; write 0x1 to r0 -> r0 still reads 0.
REQ-035 Same-cycle RegWrite r7=0x12345678 with Read_Reg1=7 -> 0x12345678 before the edge when BYPASS_EN is defined, old value when it is not.
REQ-036 Fill r1..r31 with nonzero values, pulse Clear -> Busy high for exactly 32 cycles; a write to r3 during Busy is discarded; all registers read 0 afterwards.
REQ-037 Assert rst_n=0 at sweep cycle 10 -> Busy drops immediately; after release FSM is IDLE and all registers read 0.
REQ-038 Simultaneous Clear and RegWrite r9=0xA5A5A5A5 in IDLE -> r9 reads 0xA5A5A5A5 until swept, then 0.
